// File: rtl/nonce_crc_pkg.sv
// Shared constants, state encoding and the CRC-12 bit step for the nonce CRC checker.
package nonce_crc_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned CRC_W   = 12;

  localparam logic [CRC_W-1:0] CRC12_POLY = 12'h80F;
  localparam logic [CRC_W-1:0] CRC12_INIT = 12'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // MSB-first, unreflected: feedback is the outgoing MSB xor the incoming bit.
  function automatic logic [CRC_W-1:0] crc12_step(input logic [CRC_W-1:0] crc, input logic b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC12_POLY : '0);
  endfunction

endpackage

// File: rtl/crc12_serial.sv
// Bit-serial CRC-12 engine: folds BITS_PER_CYCLE nonce bits per cycle, MSB first,
// and pulses done for one cycle once the whole word has been folded.
module crc12_serial #(
  parameter int unsigned NONCE_W        = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NONCE_W-1:0]              data,
  output logic                            done,
  output logic [nonce_crc_pkg::CRC_W-1:0] result
);
  import nonce_crc_pkg::*;

  localparam int unsigned Steps = NONCE_W / BITS_PER_CYCLE;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  logic [NONCE_W-1:0] data_q;
  logic [CRC_W-1:0]   crc_q;
  logic [CRC_W-1:0]   crc_d;
  logic [CntW-1:0]    cnt_q;
  logic               active_q;
  logic               done_q;

  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      crc_d = crc12_step(crc_d, data_q[NONCE_W-1-i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        data_q   <= data;
        crc_q    <= CRC12_INIT;
        cnt_q    <= '0;
        active_q <= 1'b1;
      end else if (active_q) begin
        crc_q  <= crc_d;
        data_q <= data_q << BITS_PER_CYCLE;
        cnt_q  <= cnt_q + CntW'(1);
        if (cnt_q == CntW'(Steps - 1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign done   = done_q;
  assign result = crc_q;

endmodule

// File: rtl/nonce_crc_checker.sv
// Checks {crc12, nonce} words, reports nonce + pass flag and counts failures (saturating).
// Optional build macro NONCE_CRC_DEDUP_EN drops a word identical to the last accepted one.
module nonce_crc_checker #(
  parameter int unsigned NONCE_W        = 32,
  parameter int unsigned CRC_W          = 12,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CRC_W+NONCE_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NONCE_W-1:0]       out_nonce,
  output logic                     out_crc_ok,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     busy
);
  import nonce_crc_pkg::*;

  state_e                     state_q;
  logic [CRC_W+NONCE_W-1:0]   word_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic [NONCE_W-1:0]         out_nonce_q;
  logic                       out_crc_ok_q;
  logic [ERR_CNT_W-1:0]       err_count_q;
  logic                       busy_q;
  logic                       dup;
  logic                       start;
  logic                       crc_done;
  logic [11:0]                crc_result;

`ifdef NONCE_CRC_DEDUP_EN
  logic [CRC_W+NONCE_W-1:0]   last_word_q;
  logic                       last_vld_q;

  assign dup = last_vld_q && (in_data == last_word_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_word_q <= '0;
      last_vld_q  <= 1'b0;
    end else if (start) begin
      last_word_q <= in_data;
      last_vld_q  <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign start = (state_q == IDLE) && in_valid && !dup;

  crc12_serial #(
    .NONCE_W        (NONCE_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data   (in_data[NONCE_W-1:0]),
    .done   (crc_done),
    .result (crc_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_nonce_q  <= '0;
      out_crc_ok_q <= 1'b0;
      err_count_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A dropped duplicate is consumed by the handshake but leaves the FSM idle.
          if (start) begin
            word_q     <= in_data;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (crc_done) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_nonce_q  <= word_q[NONCE_W-1:0];
            out_crc_ok_q <= (crc_result == word_q[NONCE_W +: CRC_W]);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            if (!out_crc_ok_q && (err_count_q != '1)) begin
              err_count_q <= err_count_q + ERR_CNT_W'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_nonce  = out_nonce_q;
  assign out_crc_ok = out_crc_ok_q;
  assign err_count  = err_count_q;
  assign busy       = busy_q;

endmodule
